// File: rtl/key_debounce_if.sv
// Signal bundle between the raw pushbuttons and the debounce stage.
// master drives the raw buttons; slave (the debouncer) drives the
// conditioned key/press/quick outputs.
interface key_debounce_if;
  logic [7:0] btn;
  logic       quick_btn;
  logic [7:0] key;
  logic [7:0] press;
  logic       quick;

  modport master (
    output btn,
    output quick_btn,
    input  key,
    input  press,
    input  quick
  );

  modport slave (
    input  btn,
    input  quick_btn,
    output key,
    output press,
    output quick
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces eight key buttons plus a speed button.
// Channels 0..7 are the keys, channel 8 is quick_btn. Each channel has a
// 2-flop synchroniser, a stable bit and a disagreement counter. The stable
// bit flips only after DEB_LEN consecutive cycles of disagreement.
module key_debounce #(
  parameter int unsigned DEB_LEN = 100000,
  parameter int unsigned CW      = 17
) (
  input  logic         clk,
  input  logic         rst,
  key_debounce_if.slave bus
);

  localparam int unsigned NCH  = 9;
  localparam logic [CW-1:0] LAST = CW'(DEB_LEN - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] stable_d;
  logic [CW-1:0]  cnt [NCH];

  logic [7:0] key_next;
  logic [7:0] key_q;
  logic [7:0] press_q;
  logic       quick_q;

  assign raw = {bus.quick_btn, bus.btn};

  // Two-flop synchroniser for all nine asynchronous inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Per-channel debounce: count disagreement cycles, flip stable at DEB_LEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle delayed copy of stable for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  // Lowest-index pressed key wins; result is zero or one-hot.
  always_comb begin
    key_next = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (stable[i] && (key_next == '0)) begin
        key_next[i] = 1'b1;
      end
    end
  end

  // Registered outputs: priority key, press pulses, quick toggle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      press_q <= '0;
      quick_q <= 1'b0;
    end else begin
      key_q   <= key_next;
      press_q <= stable[7:0] & ~stable_d[7:0];
      quick_q <= quick_q ^ (stable[8] & ~stable_d[8]);
    end
  end

  assign bus.key   = key_q;
  assign bus.press = press_q;
  assign bus.quick = quick_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with DEB_LEN=4, CW=3.
// Table vectors and hand sequences use constant expectations; a window-based
// reference model checks every cycle, including a randomized phase.
module tb_key_debounce;

  localparam int unsigned DL = 4;

  logic clk;
  logic rst;
  key_debounce_if bus ();

  key_debounce #(.DEB_LEN(DL), .CW(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic        model_on = 1'b0;

  // ---------------- reference model ----------------
  // A channel's stable value flips once the last DL synchronised samples
  // (taken since the most recent reset) all disagree with it.
  logic [8:0] m_s1, m_s2, m_stable, m_stable_d;
  logic [DL-1:0] m_hist [9];
  int unsigned   m_len;
  logic [7:0]    m_key, m_press;
  logic          m_quick;

  always @(posedge clk) begin
    logic [8:0] nstab;
    logic [7:0] lo;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0;
      for (int i = 0; i < 9; i++) m_hist[i] = '0;
      m_len = 0;
      m_key = '0; m_press = '0; m_quick = 1'b0;
    end else begin
      if (m_len < DL) m_len = m_len + 1;
      nstab = m_stable;
      for (int i = 0; i < 9; i++) begin
        m_hist[i] = {m_hist[i][DL-2:0], m_s2[i]};
        if (m_len >= DL && m_hist[i] == {DL{~m_stable[i]}}) nstab[i] = ~m_stable[i];
      end
      lo      = m_stable[7:0] & (8'd0 - m_stable[7:0]);
      m_key   = lo;
      m_press = m_stable[7:0] & ~m_stable_d[7:0];
      m_quick = m_quick ^ (m_stable[8] & ~m_stable_d[8]);
      m_stable_d = m_stable;
      m_stable   = nstab;
      m_s2 = m_s1;
      m_s1 = {bus.quick_btn, bus.btn};
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      vectors++;
      if (bus.key !== m_key || bus.press !== m_press || bus.quick !== m_quick) begin
        errors++;
        $display("FAIL model t=%0t: key=%h press=%h quick=%b, expected key=%h press=%h quick=%b",
                 $time, bus.key, bus.press, bus.quick, m_key, m_press, m_quick);
      end
    end
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic       rst;
    logic [7:0] btn;
    logic       qb;
    logic [7:0] k;
    logic [7:0] p;
    logic       q;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int unsigned n, logic r, logic [7:0] b, logic qb,
                              logic [7:0] k, logic [7:0] p, logic q);
    vec_t v;
    v.rst = r; v.btn = b; v.qb = qb; v.k = k; v.p = p; v.q = q;
    for (int unsigned i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  // Apply inputs just after a negedge, then land on the following negedge.
  task automatic step(input logic r, input logic [7:0] b, input logic qb);
    rst = r; bus.btn = b; bus.quick_btn = qb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] k, input logic [7:0] p, input logic q);
    vectors++;
    if (bus.key !== k || bus.press !== p || bus.quick !== q) begin
      errors++;
      $display("FAIL %s: key=%h press=%h quick=%b, expected key=%h press=%h quick=%b",
               name, bus.key, bus.press, bus.quick, k, p, q);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bus.btn = 8'h00; bus.quick_btn = 1'b0;
    @(negedge clk);
    model_on = 1'b1;

    // Reset with all keys held, release, then a clean press of btn[3].
    add(2, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
    add(6, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
    add(1, 1'b0, 8'hFF, 1'b0, 8'h01, 8'hFF, 1'b0);
    add(1, 1'b0, 8'hFF, 1'b0, 8'h01, 8'h00, 1'b0);
    add(6, 1'b0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0);
    add(2, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    add(6, 1'b0, 8'h08, 1'b0, 8'h00, 8'h00, 1'b0);
    add(1, 1'b0, 8'h08, 1'b0, 8'h08, 8'h08, 1'b0);
    add(5, 1'b0, 8'h08, 1'b0, 8'h08, 8'h00, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].btn, tbl[i].qb);
      chk($sformatf("table[%0d]", i), tbl[i].k, tbl[i].p, tbl[i].q);
    end

    // Bounce rejection on btn[5].
    idle(10);
    step(1'b0, 8'h20, 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h20, 1'b0); step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("bounce_quiet", 8'h00, 8'h00, 1'b0);
    end
    for (int i = 0; i <= 7; i++) begin
      step(1'b0, 8'h20, 1'b0);
      if (i < 6)       chk("bounce_wait", 8'h00, 8'h00, 1'b0);
      else if (i == 6) chk("bounce_press", 8'h20, 8'h20, 1'b0);
      else             chk("bounce_hold", 8'h20, 8'h00, 1'b0);
    end

    // Priority: btn[6] then btn[2]; releasing btn[2] falls back to btn[6].
    idle(10);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h40, 1'b0);
      if (i == 6)     chk("prio_k6", 8'h40, 8'h40, 1'b0);
      else if (i > 6) chk("prio_k6_hold", 8'h40, 8'h00, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h44, 1'b0);
      if (i < 6)       chk("prio_k2_wait", 8'h40, 8'h00, 1'b0);
      else if (i == 6) chk("prio_k2", 8'h04, 8'h04, 1'b0);
      else             chk("prio_k2_hold", 8'h04, 8'h00, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h40, 1'b0);
      if (i < 6) chk("prio_rel_wait", 8'h04, 8'h00, 1'b0);
      else       chk("prio_back_k6", 8'h40, 8'h00, 1'b0);
    end

    // Quick toggle: press, glitch, press.
    idle(10);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (i == 5) chk("quick_pre", 8'h00, 8'h00, 1'b0);
      if (i == 6) chk("quick_on", 8'h00, 8'h00, 1'b1);
    end
    idle(10);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("quick_glitch", 8'h00, 8'h00, 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (i == 5) chk("quick_pre2", 8'h00, 8'h00, 1'b1);
      if (i == 6) chk("quick_off", 8'h00, 8'h00, 1'b0);
    end
    idle(10);

    // Mid-debounce reset on btn[0].
    for (int i = 0; i < 3; i++) step(1'b0, 8'h01, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk("midrst_reset", 8'h00, 8'h00, 1'b0);
    for (int i = 0; i <= 6; i++) begin
      step(1'b0, 8'h01, 1'b0);
      if (i < 6) chk("midrst_wait", 8'h00, 8'h00, 1'b0);
      else       chk("midrst_press", 8'h01, 8'h01, 1'b0);
    end

    // Randomized phase, checked by the reference model only.
    for (int seg = 0; seg < 400; seg++) begin
      logic [7:0] b;
      logic       q;
      logic       r;
      int unsigned len;
      b   = 8'($urandom) & 8'($urandom);
      q   = 1'($urandom);
      r   = ($urandom_range(0, 39) == 0);
      len = $urandom_range(1, 12);
      for (int unsigned i = 0; i < len; i++) step(r, b, q);
    end

    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-conditioning stage that sits directly upstream of the multiplexed 7-segment counter/display block. It synchronises and debounces eight raw pushbuttons plus a separate speed button. It drives the display block's 8-bit one-hot `key` vector, which must be all-zero or exactly one-hot. It also drives its `quick` level, which toggles once per debounced press. Each debounced channel also produces a one-cycle press pulse for other consumers.

## Interface
Parameters:
- `DEB_LEN`, default 100000: number of consecutive cycles a synchronised input must differ from its stable state before the stable state flips (2 ms at 50 MHz). Legal range 2..2^20.
- `CW`, default 17: width of each debounce counter. Must satisfy 2^CW >= DEB_LEN.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `btn`, in, 8: raw key buttons, active-high (1 = pressed), asynchronous to `clk`.
- `quick_btn`, in, 1: raw speed button, active-high, asynchronous.
- `key`, out, 8: registered one-hot of the lowest-index debounced-pressed key, or 0 when none is pressed.
- `press`, out, 8: registered one-cycle pulse per key on each debounced release→pressed transition.
- `quick`, out, 1: registered speed-mode level, toggled on each debounced press of `quick_btn`.

## Operation
- There are 9 identical channels: `btn[0..7]` and `quick_btn`. Each channel contains:
  - a 2-flop synchroniser `s1 → s2`;
  - a `stable` bit;
  - a CW-bit counter `cnt`.
- Per-channel rule, evaluated every cycle:
  - If `s2 == stable`: `cnt <= 0`.
  - Else, if `cnt == DEB_LEN-1`: `stable <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- A disagreement shorter than DEB_LEN cycles resets the counter and leaves `stable` unchanged. This rule applies to both press and release bounce.
- `key <= lowest_set_onehot(stable[7:0])`.
  - Priority: index 0 is highest, index 7 is lowest.
  - Other pressed keys are ignored while a lower-index key is held.
  - When the held lower-index key releases, `key` moves to the next lowest pressed key without a press pulse.
- `press[i] <= stable[i] & ~stable_d[i]`, where `stable_d` is `stable` delayed one cycle.
  - `press` is independent of the priority rule; several bits may pulse in the same cycle.
- `quick <= quick ^ (stable_q & ~stable_q_d)`. This means exactly one toggle per debounced press; release has no effect.
- Counters saturate logically at DEB_LEN-1 because they reset on flip. They never wrap.

## Timing
- Reset, on the first rising `clk` edge with `rst`=1:
  - `s1`, `s2`, `stable`, `stable_d` and `cnt` all cleared to 0;
  - outputs `key = 8'h00`, `press = 8'h00`, `quick = 0`.
- Reset mid-debounce discards partial counts. A button held through reset is seen as a new press after reset deasserts, with full latency.
- Latency: let raw input go high before edge n and stay constant.
  - `s1` = 1 after edge n.
  - `s2` = 1 after edge n+1.
  - `stable` = 1 after edge n+DEB_LEN+1.
  - `key`, `press` and `quick` update after edge n+DEB_LEN+2.
- `press` is high for exactly one cycle and does not repeat while the key is held.
- Release latency is identical to press latency. `key` returns to 0 (or to the next pressed key) at n+DEB_LEN+2.
- Simultaneous stable flips on several channels in one cycle are all honoured in the same cycle.
- No handshake exists. The downstream block samples `key` every cycle.

## Test plan
(Benches use DEB_LEN=4, CW=3.)
- **Reset:** hold `rst` for 2 cycles with `btn=8'hFF` → `key=0`, `press=0`, `quick=0`. After release, `key=8'h01` exactly 6 edges later, and `press=8'hFF` for 1 cycle.
- **Clean press:** `btn[3]` rises and is held → `key=8'h08` and `press=8'h08` at edge n+6. `press` returns to 0 at n+7. `key` stays 8'h08 while held.
- **Bounce rejection:** `btn[5]` toggles 1,0,1,1,0 at one cycle each → no change on `key`/`press`. A subsequent steady 1 gives `key=8'h20` 6 edges after the last rising edge.
- **Priority:** press `btn[6]`, then `btn[2]` 10 cycles later → `key` goes 8'h40 then 8'h04, with `press` pulses 8'h40 then 8'h04. Release `btn[2]` → `key=8'h40` with no pulse.
- **Quick toggle:** two separate debounced presses of `quick_btn`, plus one 3-cycle glitch → `quick` goes 0→1→0, each toggle at edge n+6 of its press. The glitch causes no toggle.
- **Mid-debounce reset:** `btn[0]` high for 3 cycles, then `rst` for 1 cycle, then still high → `key=8'h01` 6 edges after `rst` deasserts.
